// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1 receiver (2-flop sync, baud tick, rx FSM, FWFT FIFO); byte on r_data the cycle after STOP.
// No backpressure: a full FIFO drops the byte with overrun_err. `define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_receiver #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR     = 54,
  parameter int DVSR_BIT = 6,
  parameter int ADDR_W   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_uart,
  output logic [7:0] r_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int SW    = (SB_TICK > 16) ? 5 : 4;
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [SW-1:0] S_START_END = SW'(7);
  localparam logic [SW-1:0] S_DATA_END  = SW'(15);
  localparam logic [SW-1:0] S_STOP_END  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
  localparam logic [DVSR_BIT-1:0] DIV_END = DVSR_BIT'(DVSR - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                sync1_q, sync2_q, rx_s;
  logic [DVSR_BIT-1:0] div_q;
  logic                tick;
  state_t              state_q, state_d;
  logic [SW-1:0]       s_q, s_d;
  logic [NW-1:0]       n_q, n_d;
  logic [DBIT-1:0]     b_q, b_d;
  logic                bit_val, good_stop, bad_stop;
  logic [ADDR_W:0]     wr_ptr_q, rd_ptr_q;
  logic [7:0]          mem_q [DEPTH];
  logic                wr_en, rd_en;

  assign rx_s = sync2_q;
  assign tick = (div_q == DIV_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      div_q   <= '0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      div_q   <= tick ? '0 : div_q + DVSR_BIT'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Two early samples are held; the third is the live sample at the decision tick.
  localparam logic [SW-1:0] S_DATA_C0 = SW'(13);
  localparam logic [SW-1:0] S_DATA_C1 = SW'(14);
  localparam logic [SW-1:0] S_STOP_C0 = SW'(SB_TICK - 3);
  localparam logic [SW-1:0] S_STOP_C1 = SW'(SB_TICK - 2);
  logic [1:0] maj_q, maj_d;
  assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
`ifdef UART_RX_MAJORITY_EN
      maj_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
`ifdef UART_RX_MAJORITY_EN
      maj_q   <= maj_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
`ifdef UART_RX_MAJORITY_EN
    maj_d     = maj_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_START_END) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
`ifdef UART_RX_MAJORITY_EN
          if (s_q == S_DATA_C0) maj_d[0] = rx_s;
          if (s_q == S_DATA_C1) maj_d[1] = rx_s;
`endif
          if (s_q == S_DATA_END) begin
            s_d = '0;
            b_d = {bit_val, b_q[DBIT-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
`ifdef UART_RX_MAJORITY_EN
          if (s_q == S_STOP_C0) maj_d[0] = rx_s;
          if (s_q == S_STOP_C1) maj_d[1] = rx_s;
`endif
          if (s_q == S_STOP_END) begin
            state_d   = IDLE;
            good_stop = bit_val;
            bad_stop  = !bit_val;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign rd_en        = rd_uart && !rx_empty && !reset;
  assign wr_en        = good_stop && (!rx_full || rd_en) && !reset;
  assign rx_done_tick = wr_en;
  assign overrun_err  = good_stop && rx_full && !rd_en && !reset;
  assign frame_err    = bad_stop && !reset;

  assign rx_empty = (wr_ptr_q == rd_ptr_q);
  assign rx_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign r_data   = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[ADDR_W-1:0]] <= 8'(b_q);
        wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: serial frames drive a queue model of the
// receive FIFO; pulse counts, flags and popped bytes are compared against it.
module tb_uart_receiver;

  localparam int DVSR  = 8;
  localparam int BIT   = 16 * DVSR;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rd_uart = 1'b0;
  logic [7:0] r_data;
  logic       rx_empty, rx_full, rx_done_tick, frame_err, overrun_err;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0, ferr_cnt = 0, oerr_cnt = 0;
  int cyc = 0, done_cyc = 0, start_cyc = 0;
  logic [7:0] mdl_q [$];

  uart_receiver #(.DBIT(8), .SB_TICK(16), .DVSR(DVSR), .DVSR_BIT(3), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_uart(rd_uart), .r_data(r_data),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_done_tick(rx_done_tick),
    .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #2;
    if (rx_done_tick === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (frame_err === 1'b1)   ferr_cnt++;
    if (overrun_err === 1'b1) oerr_cnt++;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation still running at cycle %0d, required to finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // stop_ok=0 holds the stop bit low only for its first 60% so the line is idle again afterwards.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit glitch);
    rx = 1'b0;
    start_cyc = cyc;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (glitch) begin
        wait_clk(BIT / 2 - DVSR / 2);
        rx = ~b[i];
        wait_clk(DVSR);
        rx = b[i];
        wait_clk(BIT - BIT / 2 - DVSR / 2);
      end else begin
        wait_clk(BIT);
      end
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_clk(BIT);
    end else begin
      rx = 1'b0;
      wait_clk(BIT * 6 / 10);
      rx = 1'b1;
      wait_clk(BIT - BIT * 6 / 10);
    end
    wait_clk($urandom_range(3 * BIT / 2, 3 * BIT));
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_empty"}, rx_empty, mdl_q.size() == 0);
    check_val({tag, "_full"}, rx_full, mdl_q.size() == DEPTH);
    if (mdl_q.size() > 0) check_val({tag, "_head"}, r_data, mdl_q[0]);
  endtask

  task automatic frame_chk(input logic [7:0] b, input bit stop_ok, input bit glitch, input string tag);
    int d0, f0, o0, ed, ef, eo;
    d0 = done_cnt; f0 = ferr_cnt; o0 = oerr_cnt;
    ed = 0; ef = 0; eo = 0;
    if (!stop_ok)                    ef = 1;
    else if (mdl_q.size() == DEPTH)  eo = 1;
    else begin
      ed = 1;
      mdl_q.push_back(b);
    end
    send_frame(b, stop_ok, glitch);
    check_val({tag, "_done"}, done_cnt - d0, ed);
    check_val({tag, "_ferr"}, ferr_cnt - f0, ef);
    check_val({tag, "_oerr"}, oerr_cnt - o0, eo);
    check_state(tag);
  endtask

  task automatic pop_chk(input string tag);
    check_val(tag, r_data, mdl_q.pop_front());
    rd_uart = 1'b1;
    wait_clk(1);
    rd_uart = 1'b0;
  endtask

  initial begin
    int d0, f0, o0, lat, k;
    bit seen;
    logic [7:0] head, b;

    wait_clk(5);
    check_val("rst_empty", rx_empty, 1);
    check_val("rst_full", rx_full, 0);
    check_val("rst_rdata", r_data, 0);
    check_val("rst_pulses", {rx_done_tick, frame_err, overrun_err}, 0);
    reset = 1'b0;
    wait_clk(BIT);

    frame_chk(8'h55, 1, 0, "b55");
    lat = done_cyc - start_cyc;
    check_val("b55_latency_in_window", (lat >= BIT * 19 / 2 - 2 * DVSR) && (lat <= BIT * 19 / 2 + 2 * DVSR), 1);
    pop_chk("b55_pop");
    check_state("b55_after_pop");

    frame_chk(8'hA3, 0, 0, "bA3_badstop");
    frame_chk(8'h3C, 1, 0, "b3C");
    pop_chk("b3C_pop");

    for (int i = 1; i <= 5; i++) frame_chk(8'(i), 1, 0, "fill");
    for (int i = 0; i < 4; i++) pop_chk("fill_pop");
    check_state("fill_drained");

    for (int i = 0; i < 4; i++) frame_chk(8'h11 + 8'(i), 1, 0, "refill");
    d0 = done_cnt; f0 = ferr_cnt; o0 = oerr_cnt;
    seen = 1'b0;
    head = 8'h00;
    fork
      send_frame(8'h15, 1, 0);
      begin
        for (int i = 0; i < 12 * BIT && !seen; i++) begin
          @(negedge clk);
          if (overrun_err === 1'b1) begin
            head = r_data;
            rd_uart = 1'b1;
            #1;
            check_val("simul_done_now", rx_done_tick, 1);
            check_val("simul_ovr_now", overrun_err, 0);
            @(posedge clk);
            #1;
            rd_uart = 1'b0;
            seen = 1'b1;
          end
        end
      end
    join
    check_val("simul_write_seen", seen, 1);
    if (seen) begin
      check_val("simul_head", head, mdl_q.pop_front());
      mdl_q.push_back(8'h15);
    end
    check_val("simul_done", done_cnt - d0, 1);
    check_val("simul_oerr", oerr_cnt - o0, 0);
    check_val("simul_ferr", ferr_cnt - f0, 0);
    check_state("simul");
    while (mdl_q.size() > 0) pop_chk("simul_pop");

    frame_chk(8'h42, 1, 0, "pre_glitch");
    d0 = done_cnt; f0 = ferr_cnt; o0 = oerr_cnt;
    rx = 1'b0;
    wait_clk(5 * DVSR);
    rx = 1'b1;
    wait_clk(2 * BIT);
    check_val("glitch_pulses", (done_cnt - d0) + (ferr_cnt - f0) + (oerr_cnt - o0), 0);
    check_state("glitch");
    pop_chk("glitch_pop");

    frame_chk(8'h66, 1, 0, "pre_rst");
    frame_chk(8'h99, 1, 0, "pre_rst");
    d0 = done_cnt; f0 = ferr_cnt; o0 = oerr_cnt;
    rx = 1'b0;
    wait_clk(BIT);
    rx = 1'b1;
    wait_clk(3 * BIT);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    mdl_q.delete();
    check_state("midrst");
    check_val("midrst_rdata", r_data, 0);
    wait_clk(2 * BIT);
    check_val("midrst_pulses", (done_cnt - d0) + (ferr_cnt - f0) + (oerr_cnt - o0), 0);
    frame_chk(8'h81, 1, 0, "b81");
    pop_chk("b81_pop");

`ifdef UART_RX_MAJORITY_EN
    frame_chk(8'h00, 1, 1, "maj00");
    pop_chk("maj00_pop");
`endif

    for (int r = 0; r < 12; r++) begin
      b = 8'($urandom);
      frame_chk(b, $urandom_range(0, 5) != 0, 0, "rnd");
      k = $urandom_range(0, 2);
      for (int j = 0; j < k && mdl_q.size() > 0; j++) pop_chk("rnd_pop");
    end
    while (mdl_q.size() > 0) pop_chk("drain_pop");
    check_state("drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
